// File: rtl/div_unit.sv
// Multi-cycle restoring divider with signed/unsigned modes, one quotient bit per cycle.
// Results are registered on entry to DONE and held until the next completed divide.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               signed_q, signed_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               dbz_q, dbz_d;

  logic               a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   a_in_mag, b_mag;
  logic [WIDTH:0]     shifted, diff;
  logic               ge;
  logic [WIDTH-1:0]   rem_step, quo_step, q_final, r_final;

  // One restoring step: the dividend magnitude shifts out of quo_q as quotient bits shift in.
  always_comb begin
    a_neg    = signed_q & a_q[WIDTH-1];
    b_neg    = signed_q & b_q[WIDTH-1];
    b_zero   = (b_q == '0);
    a_in_mag = (is_signed & a[WIDTH-1]) ? -a : a;
    b_mag    = b_neg ? -b_q : b_q;
    shifted  = {rem_q, quo_q[WIDTH-1]};
    diff     = shifted - {1'b0, b_mag};
    ge       = ~diff[WIDTH];
    rem_step = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_step = {quo_q[WIDTH-2:0], ge};
    // Divide by zero bypasses sign fix-up so the remainder is the raw dividend.
    q_final  = b_zero ? '1 : ((a_neg ^ b_neg) ? -quo_step : quo_step);
    r_final  = b_zero ? a_q : (a_neg ? -rem_step : rem_step);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    signed_d    = signed_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    if (cancel) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          state_d = StIdle;
          if (start) begin
            state_d  = StRun;
            cnt_d    = CntW'(WIDTH);
            a_d      = a;
            b_d      = b;
            signed_d = is_signed;
            rem_d    = '0;
            quo_d    = a_in_mag;
          end
        end
        StRun: begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_d     = StDone;
            quotient_d  = q_final;
            remainder_d = r_final;
            dbz_d       = b_zero;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      signed_q    <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      signed_q    <= signed_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == StRun);
  assign valid       = (state_q == StDone);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
